// File: rtl/sram_responder.sv
// Async SRAM bus responder: stands in for the external RAM chip so the SRAM
// controller can be looped back on-board. Backed by a small register array.
module sram_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Ram_EN,
  input  logic              Ram_OE,
  input  logic              Ram_WE,
  input  logic [17:0]       Ram_address,
  inout  wire  [DATA_W-1:0] Ram_data,
  input  logic              clr_err,
  output logic [15:0]       wr_count,
  output logic [17:0]       last_addr,
  output logic [DATA_W-1:0] last_data,
  output logic              err_conflict,
  output logic              err_range
);

  typedef enum logic [2:0] {IDLE, READ, WLOW, COMMIT, ERR} state_t;

  // Strobes are packed {EN, OE, WE}; the last stage of each chain is the synchronized view.
  logic [SYNC_STAGES-1:0][2:0]        strb_q, strb_d;
  logic [SYNC_STAGES-1:0][17:0]       addr_sync_q, addr_sync_d;
  logic [SYNC_STAGES-1:0][DATA_W-1:0] data_sync_q, data_sync_d;

  logic              s_en, s_oe, s_we;
  logic [17:0]       s_addr;
  logic [DATA_W-1:0] s_data;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  state_t            state_q, state_d;
  logic              drive_q, drive_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [17:0]       waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [15:0]       wr_count_q, wr_count_d;
  logic [17:0]       last_addr_q, last_addr_d;
  logic [DATA_W-1:0] last_data_q, last_data_d;
  logic              err_conflict_q, err_conflict_d;
  logic              err_range_q, err_range_d;
  logic              mem_we, set_conflict, set_range;
  logic [DATA_W-1:0] rd_word;

  function automatic logic in_range(input logic [17:0] a);
    return a[17:ADDR_W] == '0;
  endfunction

  always_comb begin
    strb_d      = {strb_q[SYNC_STAGES-2:0], Ram_EN, Ram_OE, Ram_WE};
    addr_sync_d = {addr_sync_q[SYNC_STAGES-2:0], Ram_address};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], Ram_data};
  end

  assign s_en   = strb_q[SYNC_STAGES-1][2];
  assign s_oe   = strb_q[SYNC_STAGES-1][1];
  assign s_we   = strb_q[SYNC_STAGES-1][0];
  assign s_addr = addr_sync_q[SYNC_STAGES-1];
  assign s_data = data_sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d      = state_q;
    drive_d      = 1'b0;
    rd_word      = in_range(s_addr) ? mem[s_addr[ADDR_W-1:0]] : '1;
    rdata_d      = rd_word;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    wr_count_d   = wr_count_q;
    last_addr_d  = last_addr_q;
    last_data_d  = last_data_q;
    mem_we       = 1'b0;
    set_conflict = 1'b0;
    set_range    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!s_en) begin
          if (!s_oe && !s_we) begin
            state_d = ERR;
          end else if (!s_oe) begin
            state_d   = READ;
            drive_d   = 1'b1;
            set_range = !in_range(s_addr);
          end else if (!s_we) begin
            state_d = WLOW;
            waddr_d = s_addr;
            wdata_d = s_data;
          end
        end
      end
      READ: begin
        if (!s_we) begin
          state_d = ERR;
        end else if (s_en || s_oe) begin
          state_d = IDLE;
        end else begin
          drive_d   = 1'b1;
          set_range = !in_range(s_addr);
        end
      end
      // A write completing (WE high) takes priority over EN rising in the same cycle.
      WLOW: begin
        if (!s_oe) begin
          state_d = ERR;
        end else if (s_we) begin
          state_d = COMMIT;
        end else if (s_en) begin
          state_d = IDLE;
        end else begin
          waddr_d = s_addr;
          wdata_d = s_data;
        end
      end
      COMMIT: begin
        state_d = IDLE;
        if (in_range(waddr_q)) begin
          mem_we      = 1'b1;
          wr_count_d  = wr_count_q + 16'd1;
          last_addr_d = waddr_q;
          last_data_d = wdata_q;
        end else begin
          set_range = 1'b1;
        end
      end
      ERR: begin
        set_conflict = 1'b1;
        if (s_oe && s_we) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    err_conflict_d = (err_conflict_q & ~clr_err) | set_conflict;
    err_range_d    = (err_range_q & ~clr_err) | set_range;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      strb_q         <= '1;
      state_q        <= IDLE;
      drive_q        <= 1'b0;
      wr_count_q     <= '0;
      last_addr_q    <= '0;
      last_data_q    <= '0;
      err_conflict_q <= 1'b0;
      err_range_q    <= 1'b0;
    end else begin
      strb_q         <= strb_d;
      state_q        <= state_d;
      drive_q        <= drive_d;
      wr_count_q     <= wr_count_d;
      last_addr_q    <= last_addr_d;
      last_data_q    <= last_data_d;
      err_conflict_q <= err_conflict_d;
      err_range_q    <= err_range_d;
    end
  end

  always_ff @(posedge CLK) begin
    addr_sync_q <= addr_sync_d;
    data_sync_q <= data_sync_d;
    rdata_q     <= rdata_d;
    waddr_q     <= waddr_d;
    wdata_q     <= wdata_d;
    if (mem_we && !RST) mem[waddr_q[ADDR_W-1:0]] <= wdata_q;
  end

  assign Ram_data     = drive_q ? rdata_q : {DATA_W{1'bz}};
  assign wr_count     = wr_count_q;
  assign last_addr    = last_addr_q;
  assign last_data    = last_data_q;
  assign err_conflict = err_conflict_q;
  assign err_range    = err_range_q;

endmodule
